// File: rtl/rout_trace_buffer.sv
// rout_trace_buffer: observes the KGP_RISC result bus and records every change
// of value, together with a free-running cycle timestamp, in a show-ahead FIFO.
// A valid/ready port unloads the FIFO. Captures that find the FIFO full are
// dropped and counted, so lost results stay visible on long program runs.
module rout_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rout,
  input  logic              trace_en,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TS_W-1:0]   out_ts,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  // Storage arrays: contents only matter where the pointers say so, so they
  // carry no reset and are masked at the output when the FIFO is empty.
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [TS_W-1:0]   ts_mem_q   [DEPTH];

  logic [TS_W-1:0]   ts_q,        ts_d;
  logic [DATA_W-1:0] last_rout_q, last_rout_d;
  logic              first_q,     first_d;
  logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]     count_q,     count_d;
  logic              overflow_q,  overflow_d;
  logic [7:0]        drop_cnt_q,  drop_cnt_d;

  logic full_s;
  logic empty_s;
  logic cap_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Decode this cycle's capture, pop, push and drop events.
  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    // A capture happens on the first enabled cycle and on every value change.
    cap_s   = trace_en && (first_q || (rout != last_rout_q));
    pop_s   = !empty_s && out_ready && !clear;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_s  = cap_s && (!full_s || pop_s) && !clear;
    drop_s  = cap_s && full_s && !pop_s && !clear;
  end

  // Next-state computation for timestamp, change detector, pointers and stats.
  always_comb begin
    ts_d = ts_q + TS_W'(1);

    // The change detector tracks rout even when the entry is dropped or cleared.
    if (cap_s) begin
      last_rout_d = rout;
    end else begin
      last_rout_d = last_rout_q;
    end

    // Disabling or clearing re-arms the unconditional first capture.
    if (clear || !trace_en) begin
      first_d = 1'b1;
    end else if (cap_s) begin
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end

    if (clear) begin
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      // Drop counter saturates so a long stall cannot wrap it back to small values.
      if (drop_s && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q        <= {TS_W{1'b0}};
      last_rout_q <= {DATA_W{1'b0}};
      first_q     <= 1'b1;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      ts_q        <= ts_d;
      last_rout_q <= last_rout_d;
      first_q     <= first_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Entry write: the value and the timestamp of the capturing cycle.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_q[wr_ptr_q] <= rout;
      ts_mem_q[wr_ptr_q]   <= ts_q;
    end
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    if (empty_s) begin
      out_data = {DATA_W{1'b0}};
      out_ts   = {TS_W{1'b0}};
    end else begin
      out_data = data_mem_q[rd_ptr_q];
      out_ts   = ts_mem_q[rd_ptr_q];
    end
  end

  assign out_valid = !empty_s;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rout_trace_buffer.sv
// Self-checking bench for rout_trace_buffer: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_rout_trace_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] rout = '0;
  logic              trace_en = 1'b0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] q_data [$];
  logic [TS_W-1:0]   q_ts   [$];
  logic [TS_W-1:0]   m_ts;
  logic [DATA_W-1:0] m_last;
  bit                m_first;
  bit                m_ovf;
  int                m_drop;

  rout_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .rout(rout), .trace_en(trace_en), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ts(out_ts), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_data.delete();
    q_ts.delete();
    m_ts = '0;
    m_last = '0;
    m_first = 1'b1;
    m_ovf = 1'b0;
    m_drop = 0;
  endtask

  // One clock of the reference behaviour, from the current inputs.
  task automatic model_clock();
    bit pop;
    bit cap;
    pop = (q_data.size() != 0) && out_ready;
    cap = trace_en && (m_first || (rout != m_last));
    if (clear) begin
      q_data.delete();
      q_ts.delete();
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_ts.pop_front());
      end
      if (cap) begin
        if (q_data.size() < DEPTH) begin
          q_data.push_back(rout);
          q_ts.push_back(m_ts);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (cap) m_last = rout;
    if (clear || !trace_en) m_first = 1'b1;
    else if (cap) m_first = 1'b0;
    m_ts = m_ts + 16'd1;
  endtask

  task automatic check_all(input string tag);
    bit empty;
    empty = (q_data.size() == 0);
    chk({tag, "_valid"}, 64'(out_valid), 64'(!empty));
    chk({tag, "_count"}, 64'(count), 64'(q_data.size()));
    chk({tag, "_data"}, 64'(out_data), empty ? 64'd0 : 64'(q_data[0]));
    chk({tag, "_ts"}, 64'(out_ts), empty ? 64'd0 : 64'(q_ts[0]));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] held;

    // Reset state
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);

    // 1. Basic capture
    trace_en = 1'b1;
    rout = 32'h0;
    reset = 1'b1;
    cycle("t1a");
    chk("t1_first_valid", 64'(out_valid), 64'd1);
    chk("t1_first_ts", 64'(out_ts), 64'd0);
    cycle("t1b");
    cycle("t1c");
    rout = 32'h0000_002A;
    cycle("t1d");
    chk("t1_count2", 64'(count), 64'd2);

    // 2. Duplicate suppression and re-enable
    rout = 32'd5; cycle("t2a");
    rout = 32'd5; cycle("t2b");
    rout = 32'd5; cycle("t2c");
    rout = 32'd7; cycle("t2d");
    chk("t2_count4", 64'(count), 64'd4);
    trace_en = 1'b0; cycle("t2e");
    trace_en = 1'b1; cycle("t2f");
    chk("t2_recapture", 64'(count), 64'd5);
    trace_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle("t2drain");

    // 3. Overflow and saturation
    out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rout = 32'h100 + 32'(i);
      cycle("t3fill");
    end
    chk("t3_count16", 64'(count), 64'd16);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_drop4", 64'(drop_cnt), 64'd4);
    chk("t3_head", 64'(out_data), 64'h100);
    trace_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle("t3drain");
    out_ready = 1'b0; trace_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rout = 32'h1000 + 32'(i);
      cycle("t3sat");
    end
    chk("t3_drop255", 64'(drop_cnt), 64'd255);

    // 4. Full with simultaneous push/pop
    clear = 1'b1; cycle("t4clr");
    clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rout = 32'h2000 + 32'(i);
      cycle("t4fill");
    end
    out_ready = 1'b1; rout = 32'h0000_BEEF;
    cycle("t4pp");
    chk("t4_count16", 64'(count), 64'd16);
    chk("t4_nodrop", 64'(drop_cnt), 64'd0);
    trace_en = 1'b0;
    for (int i = 0; i < 15; i++) cycle("t4drain");
    chk("t4_last", 64'(out_data), 64'h0000_BEEF);
    cycle("t4end");

    // 5. Backpressure hold, then clear with capture pending
    trace_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      rout = 32'h3000 + 32'(i);
      held = out_data;
      cycle("t5bp");
      if (!i[0] && (i > 0)) chk("t5_hold", 64'(out_data), 64'(held));
    end
    clear = 1'b1; cycle("t5clr0");
    clear = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rout = 32'h4000 + 32'(i);
      cycle("t5fill");
    end
    trace_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) cycle("t5drain");
    chk("t5_count9", 64'(count), 64'd9);
    trace_en = 1'b1; out_ready = 1'b0; rout = 32'h5555; clear = 1'b1;
    cycle("t5clr");
    chk("t5_clr_count", 64'(count), 64'd0);
    chk("t5_clr_valid", 64'(out_valid), 64'd0);
    chk("t5_clr_ovf", 64'(overflow), 64'd0);
    clear = 1'b0;
    cycle("t5first");
    chk("t5_first_cap", 64'(out_data), 64'h5555);

    // 6. Asynchronous reset mid-drain
    for (int i = 0; i < 6; i++) begin
      rout = 32'h6000 + 32'(i);
      cycle("t6fill");
    end
    out_ready = 1'b1; trace_en = 1'b0;
    cycle("t6drain");
    chk("t6_count6", 64'(count), 64'd6);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    trace_en = 1'b1; out_ready = 1'b0; rout = 32'h77;
    reset = 1'b1;
    cycle("t6rel");
    chk("t6_ts0", 64'(out_ts), 64'd0);
    chk("t6_data", 64'(out_data), 64'h77);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      trace_en = ($urandom_range(0, 7) != 0);
      rout = 32'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 49) == 0);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rout_trace_buffer.md
Name: rout_trace_buffer

Overview:
- Downstream observer of the KGP_RISC core.
- Watches the core's 32-bit `rout` result bus and captures every change of value into a FIFO, together with a cycle timestamp.
- The bench or a UART/debug drainer unloads the FIFO through a valid/ready port.
- Drop accounting makes lost results visible during long program runs.

Parameters:
- DATA_W, 32, width of rout and out_data
- DEPTH, 16, FIFO entries (power of two, ≥2)
- TS_W, 16, timestamp counter width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- rout  input  DATA_W  result bus from KGP_RISC
- trace_en  input  1  capture enable
- clear  input  1  synchronous flush of FIFO and drop statistics
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_data  output  DATA_W  captured rout value at head
- out_ts  output  TS_W  timestamp of head entry
- count  output  log2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: at least one capture dropped
- drop_cnt  output  8  saturating count of dropped captures

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, out_data=0, out_ts=0, count=0, overflow=0, drop_cnt=0.
  - Timestamp counter ts=0, last_rout=0, first=1.
  - Read and write pointers = 0.
- Timestamp: ts increments by 1 every cycle reset is deasserted and wraps modulo 2^TS_W. clear does not affect ts.
- Capture condition cap = trace_en && (first || rout != last_rout), evaluated every cycle.
  - When cap=1: last_rout<=rout and first<=0, whether or not the entry is stored.
  - When trace_en=0: first<=1, so the first cycle after re-enable always captures.
- Push: if cap=1 and (count<DEPTH or pop this cycle), write {rout, ts} at the write pointer; pointer wraps at DEPTH.
- Pop: pop = out_valid && out_ready. Advances the read pointer with wrap.
- Simultaneous push and pop:
  - count is unchanged.
  - Push is allowed even when full.
  - When empty, out_valid=0 so no pop occurs.
- Drop: cap=1, count==DEPTH, no pop.
  - Entry is discarded.
  - overflow<=1.
  - drop_cnt increments, saturating at 255.
- FIFO is show-ahead:
  - out_valid = (count != 0).
  - out_data/out_ts are combinationally the head entry, and are 0 when empty.
  - Latency rout change → out_valid: 1 cycle (captured on edge N, visible after edge N).
- Holding: out_data/out_ts must stay stable while out_valid=1 and out_ready=0.
- clear=1 has priority over push, pop and drop in the same cycle:
  - count<=0, both pointers<=0.
  - overflow<=0, drop_cnt<=0, first<=1.
  - The concurrent capture is not stored; last_rout is still updated.
- Reset mid-operation: all contents discarded immediately (async); no partial output transaction survives.
- count is always in 0..DEPTH; never underflows or exceeds DEPTH.

Test Plan:
1. Basic capture:
   - Stimulus: release reset at ts=0, trace_en=1, rout=0 held 3 cycles, then rout=0x0000002A.
   - Required: two entries, {0x0, 0} then {0x2A, 3}; out_valid rises 1 cycle after each capture; count=2 with out_ready=0.
2. Duplicate suppression:
   - Stimulus: rout toggles 5→5→5→7 with trace_en=1 after the first capture.
   - Required: only 5 and 7 are stored.
   - Then trace_en 1→0→1 with rout=7 held: 7 is captured again.
3. Overflow:
   - Stimulus: out_ready=0, 20 distinct rout values on consecutive cycles.
   - Required: count=16, overflow=1, drop_cnt=4; draining yields the first 16 values in order.
   - Then 300 more distinct values while full: drop_cnt saturates at 255.
4. Full with simultaneous push/pop:
   - Stimulus: FIFO full, out_ready=1 and new rout value in the same cycle.
   - Required: count stays 16, no drop, the new value appears as the last entry.
5. Backpressure and clear:
   - Stimulus: out_ready toggled 1010…; verify out_data holds while ready=0.
   - Stimulus: assert clear with cap=1 and count=9.
   - Required: next cycle count=0, out_valid=0, overflow=0; the following cycle captures the current rout (first=1).
6. Async reset mid-drain:
   - Stimulus: reset=0 asserted between clock edges with count=6.
   - Required: out_valid, count, out_data drop to 0 immediately; timestamp restarts at 0 after release.
